conv_sequencer: RTL
===================

CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameter IMG_W, default 32, image width in pixels (5 PE columns + 27-deep line delay).
REQ-002 Parameter IMG_H, default 32, image height in rows.
REQ-003 Parameter K, default 5, kernel size; weight count K*K = 25.
REQ-004 Parameter LAT, default 5, cycles from a window-completing pixel on oX to its result on iY.
REQ-005 iCLK  in  1  single clock, rising edge.
REQ-006 iRSTn  in  1  reset, asynchronous, active-low.
REQ-007 iStart  in  1  one-cycle request to begin a frame; honoured only in IDLE.
REQ-008 iReuseW  in  1  sampled with iStart; 1 = skip weight load.
REQ-009 iWdata  in  8  weight word from host.
REQ-010 iWvalid / oWready  in/out  1/1  weight handshake; a transfer occurs when both are 1.
REQ-011 iPix  in  8  pixel from host, raster order.
REQ-012 iPixValid / oPixReady  in/out  1/1  pixel handshake.
REQ-013 oW, oADDR, oWren  out  8/5/1  weight write port to the datapath.
REQ-014 oX  out  8  pixel to the datapath; oXValid  out  1  marks a live pixel.
REQ-015 iY  in  16  saturated datapath result.
REQ-016 oY  out  16  result; oValid  out  1  marks a valid output-window result.
REQ-017 oBusy, oDone, oErr  out  1 each  status: not-IDLE, end-of-frame pulse, stream-gap error pulse.

Function
REQ-018 The FSM SHALL use states IDLE, LOAD_W, STREAM, DRAIN, DONE.
REQ-019 IDLE: iStart=1 with iReuseW=0 SHALL go to LOAD_W; with iReuseW=1 SHALL go to STREAM; iStart in any other state SHALL be ignored.
REQ-020 LOAD_W: oWready=1; each transfer SHALL drive oWren=1, oW=iWdata, oADDR=wcnt in the same cycle, then increment wcnt 0..24.
REQ-021 The transfer at wcnt=24 SHALL move the FSM to STREAM on the next cycle, with wcnt cleared.
REQ-022 STREAM: oPixReady=1; each accepted pixel SHALL drive oX=iPix and oXValid=1 in the same cycle, and SHALL advance col 0..IMG_W-1, wrapping to 0 with row+1.
REQ-023 Because the datapath shifts every clock, a cycle in STREAM with iPixValid=0 SHALL pulse oErr for 1 cycle, SHALL NOT count, and SHALL return the FSM to IDLE.
REQ-024 A window flag SHALL be set for an accepted pixel with row>=K-1 and col>=K-1.
REQ-025 The window flag SHALL be delayed LAT cycles through a shift register cleared on reset; oValid SHALL equal the delayed flag.
REQ-026 oY SHALL equal iY when oValid=1, else 16'h0000.
REQ-027 Acceptance of pixel (IMG_H-1, IMG_W-1) SHALL move the FSM to DRAIN; oPixReady SHALL be 0 outside STREAM.
REQ-028 DRAIN SHALL last exactly LAT cycles, counted by a counter.
REQ-029 DONE SHALL last 1 cycle with oDone=1, then return to IDLE.
REQ-030 Per frame, oValid SHALL assert exactly (IMG_H-K+1)*(IMG_W-K+1) times (784 at defaults); each row burst SHALL be IMG_W-K+1 consecutive cycles.
REQ-031 oBusy SHALL be 1 in every state except IDLE.
REQ-032 oWren and oXValid SHALL never be 1 in the same cycle.

Reset
REQ-033 iRSTn=0 SHALL asynchronously force IDLE and clear wcnt, row, col, the drain counter and the delay line.
REQ-034 During reset, all outputs SHALL be 0.
REQ-035 Reset mid-frame SHALL discard all progress; weights already written to the datapath are not rewritten.

Verification
REQ-036 Reset, then iStart with iReuseW=0 and 25 back-to-back weights 1..25: oADDR 0..24 paired with oW 1..25, oWren asserted 25 cycles, STREAM entered next cycle.
REQ-037 Weight load with iWvalid toggling every other cycle: exactly 25 writes, oADDR contiguous, no duplicate addresses.
REQ-038 iReuseW=1 start, contiguous 32x32 frame: first oValid exactly LAT cycles after pixel (4,4) is accepted; 784 oValid total; oDone exactly LAT+1 cycles after the last pixel.
REQ-039 iPixValid dropped at pixel (10,7): oErr pulses 1 cycle, FSM returns to IDLE, oBusy=0; a following iStart is accepted.
REQ-040 iRSTn asserted in DRAIN: all outputs 0 immediately, no oDone, no further oValid.
REQ-041 iStart pulsed during STREAM: no effect on counters, state, or oValid count.

Source files
------------

// File: rtl/conv_sequencer.sv
// conv_sequencer: frame sequencer for a KxK convolution datapath (weight load, pixel stream, drain, done).
// Latency: weight/pixel pass-through is combinational in the accepting cycle; oValid trails the window-completing pixel by LAT cycles.
// Backpressure: none into the stream; a missing pixel in STREAM pulses oErr and aborts the frame back to IDLE.
// Ports: iCLK/iRSTn clock and async active-low reset; iStart/iReuseW frame request;
//        iWdata/iWvalid/oWready host weight handshake; oW/oADDR/oWren datapath weight write port;
//        iPix/iPixValid/oPixReady host pixel handshake; oX/oXValid datapath pixel;
//        iY datapath result; oY/oValid gated result; oBusy/oDone/oErr status.
module conv_sequencer #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int K     = 5,
  parameter int LAT   = 5
) (
  input  logic        iCLK,
  input  logic        iRSTn,
  input  logic        iStart,
  input  logic        iReuseW,
  input  logic [7:0]  iWdata,
  input  logic        iWvalid,
  output logic        oWready,
  input  logic [7:0]  iPix,
  input  logic        iPixValid,
  output logic        oPixReady,
  output logic [7:0]  oW,
  output logic [4:0]  oADDR,
  output logic        oWren,
  output logic [7:0]  oX,
  output logic        oXValid,
  input  logic [15:0] iY,
  output logic [15:0] oY,
  output logic        oValid,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int DW = $clog2(LAT + 1);

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_K      = CW'(K - 1);
  localparam logic [RW-1:0] ROW_K      = RW'(K - 1);
  localparam logic [4:0]    WCNT_LAST  = 5'(K * K - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  state_t        state;
  logic [4:0]    wcnt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] dcnt;
  logic [LAT-1:0] dly;

  logic w_xfer;
  logic px_acc;
  logic win;

  // Transfers are qualified only by state and the host valid; both ready
  // outputs are pure functions of state so no extra term is needed.
  assign w_xfer = (state == LOAD_W) && iWvalid;
  assign px_acc = (state == STREAM) && iPixValid;
  assign win    = px_acc && (row >= ROW_K) && (col >= COL_K);

  assign oWready   = (state == LOAD_W);
  assign oPixReady = (state == STREAM);
  assign oWren     = w_xfer;
  assign oW        = w_xfer ? iWdata : 8'h00;
  assign oADDR     = w_xfer ? wcnt : 5'd0;
  assign oXValid   = px_acc;
  assign oX        = px_acc ? iPix : 8'h00;
  // The datapath shifts every clock, so a bubble corrupts every window in flight.
  assign oErr      = (state == STREAM) && !iPixValid;
  assign oBusy     = (state != IDLE);
  assign oDone     = (state == DONE);
  assign oValid    = dly[LAT-1];
  assign oY        = oValid ? iY : 16'h0000;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state <= IDLE;
      wcnt  <= '0;
      col   <= '0;
      row   <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wcnt <= '0;
          col  <= '0;
          row  <= '0;
          dcnt <= '0;
          if (iStart) state <= iReuseW ? STREAM : LOAD_W;
        end
        LOAD_W: begin
          if (iWvalid) begin
            if (wcnt == WCNT_LAST) begin
              wcnt  <= '0;
              state <= STREAM;
            end else begin
              wcnt <= wcnt + 5'd1;
            end
          end
        end
        STREAM: begin
          if (!iPixValid) begin
            state <= IDLE;
          end else if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) begin
              row   <= '0;
              state <= DRAIN;
            end else begin
              row <= row + RW'(1);
            end
          end else begin
            col <= col + CW'(1);
          end
        end
        DRAIN: begin
          if (dcnt == DRAIN_LAST) begin
            dcnt  <= '0;
            state <= DONE;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Window flags ride alongside the datapath pipeline; it keeps shifting in
  // every state so results already in flight still emerge.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) dly <= '0;
    else        dly <= LAT'({dly, win});
  end

endmodule
